// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding and default parameters for the SPI counter slave.
package spi_pkg;
    localparam int SPI_WIDTH_DEFAULT = 16;
    localparam int SPI_SYNC_DEFAULT  = 2;
    typedef enum logic [1:0] {IDLE, SHIFT, LOAD, ABORT} spi_state_e;
endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop synchronizer for one asynchronous bit plus a rise/fall detector.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    // Top bit is the edge-detector history flop behind the synchronizer chain.
    logic [STAGES:0] r_sync;
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_sync <= {(STAGES + 1){RST_VAL}};
        else        r_sync <= {r_sync[STAGES-1:0], i_d};
    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_sync[STAGES];
    assign o_fall  = ~r_sync[STAGES-1] & r_sync[STAGES];
endmodule

// File: rtl/spi_counter_slave.sv
// spi_counter_slave: mode-0 SPI slave that commits complete WIDTH-bit frames to o_data
// and echoes the previously committed value on MISO.
module spi_counter_slave
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = SPI_SYNC_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_sclk,
    input  logic             i_mosi,
    input  logic             i_cs_n,
    output logic             o_miso,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_frame_err,
    output logic             o_busy
);
    localparam int CW = $clog2(WIDTH + 1);
    logic w_sclk, w_sclk_rise, w_sclk_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_cs, w_cs_rise, w_cs_fall;
    logic w_full, w_good, w_start, w_end, w_unused;
    spi_state_e r_state, w_next;
    logic [WIDTH-1:0] r_shift, r_tx, r_data;
    logic [CW-1:0] r_cnt;
    logic r_ovr, r_valid, r_err, r_armed;
    logic [SYNC_STAGES:0] r_flush;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .reset(reset), .i_d(i_sclk),
        .o_level(w_sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .reset(reset), .i_d(i_mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .reset(reset), .i_d(i_cs_n),
        .o_level(w_cs), .o_rise(w_cs_rise), .o_fall(w_cs_fall));

    assign w_unused = &{1'b0, w_sclk, w_mosi_rise, w_mosi_fall};
    assign w_full   = r_cnt == CW'(WIDTH);
    assign w_good   = w_full & ~r_ovr;
    // A cs_n fall only counts once cs_n has been seen high after reset, so a
    // reset released mid-frame cannot start on the tail of that frame.
    assign w_start  = (r_state == IDLE) & r_armed & w_cs_fall;
    assign w_end    = (r_state == SHIFT) & w_cs_rise;

    always_comb begin
        w_next = r_state;
        w_next = w_start ? SHIFT :
                 w_end ? (w_good ? LOAD : ABORT) :
                 (r_state == LOAD || r_state == ABORT) ? IDLE : r_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_tx    <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_ovr   <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_armed <= 1'b0;
            r_flush <= '0;
        end else begin
            r_state <= w_next;
            r_valid <= w_end & w_good;
            r_err   <= w_end & ~w_good;
            r_flush <= {r_flush[SYNC_STAGES-1:0], 1'b1};
            r_armed <= r_armed | (r_flush[SYNC_STAGES] & w_cs);
            if (w_end & w_good) r_data <= r_shift;
            if (w_start) begin
                r_cnt   <= '0;
                r_ovr   <= 1'b0;
                r_shift <= '0;
                r_tx    <= r_data;
            end else if (r_state == SHIFT) begin
                if (w_sclk_rise) begin
                    if (w_full) r_ovr <= 1'b1;
                    else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_shift <= {r_shift[WIDTH-2:0], w_mosi};
                    end
                end
                if (w_sclk_fall) r_tx <= r_tx << 1;
            end
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_err;
    assign o_busy      = r_state == SHIFT;
    assign o_miso      = (r_state == SHIFT) & r_tx[WIDTH-1];
endmodule

// File: doc/spi_counter_slave.md
SPI_COUNTER_SLAVE -- requirements
Module: spi_counter_slave

Interface
REQ-001 Parameter WIDTH, default 16, frame length in bits and the received counter width; legal values are 8 and 16.
REQ-002 Parameter SYNC_STAGES, default 2, the number of synchronizer flops on each SPI input.
REQ-003 clk  input  1  system clock (100 MHz); the only clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 i_sclk  input  1  SPI serial clock from the master (mode 0), asynchronous to clk.
REQ-006 i_mosi  input  1  master-out data, MSB first.
REQ-007 i_cs_n  input  1  active-low chip select framing one transfer.
REQ-008 o_miso  output  1  slave-out data, MSB first.
REQ-009 o_data  output  WIDTH  last committed counter value.
REQ-010 o_valid  output  1  one-cycle pulse when o_data updates.
REQ-011 o_frame_err  output  1  one-cycle pulse when a malformed frame is discarded.
REQ-012 o_busy  output  1  high while a frame is in progress (FSM state SHIFT).

Function
REQ-013 i_sclk, i_mosi and i_cs_n SHALL each pass through SYNC_STAGES flops, followed by a one-flop rise/fall edge detector.
REQ-014 The supported SCLK frequency SHALL be at most clk/8; faster SCLK is outside the contract.
REQ-015 The FSM SHALL have four states:
- IDLE: entered on reset; goes to SHIFT on a synchronized cs_n fall.
- SHIFT: samples data as in REQ-016.
- LOAD: lasts 1 cycle, then returns to IDLE.
- ABORT: lasts 1 cycle, then returns to IDLE.
REQ-016 In SHIFT, on each synchronized sclk rise, the FSM SHALL left-shift mosi into the shift register and increment a bit counter whose width is $clog2(WIDTH+1).
REQ-017 In SHIFT, on a synchronized cs_n rise, the FSM SHALL go to LOAD if the bit count equals WIDTH exactly, and to ABORT otherwise (fewer or more bits).
REQ-018 When the bit count reaches WIDTH, the counter SHALL saturate; any extra rising edges set a sticky overrun flag that forces ABORT.
REQ-019 In LOAD, o_data SHALL take the shift-register value and o_valid SHALL be high for exactly that one cycle.
REQ-020 In ABORT, o_frame_err SHALL be high for one cycle; o_data SHALL hold its previous value and o_valid SHALL stay low.
REQ-021 o_valid SHALL assert no later than SYNC_STAGES+2 clk cycles after the i_cs_n rise at the pin.
REQ-022 MISO operation:
- On entry to SHIFT, a transmit register SHALL load o_data and drive its MSB on o_miso.
- On each synchronized sclk fall in SHIFT, the transmit register SHALL shift left and present the next bit.
- Outside SHIFT, o_miso SHALL be 0.
REQ-023 A cs_n fall and a cs_n rise SHALL never both be detected in the same cycle by construction; a cs_n pulse shorter than one synchronized sample SHALL be ignored.
REQ-024 An sclk edge in IDLE, LOAD or ABORT SHALL be ignored and SHALL NOT alter the shift register.

Reset
REQ-025 reset low SHALL asynchronously clear the FSM to IDLE and clear o_data, o_valid, o_frame_err, o_busy, o_miso, the bit counter and the overrun flag to 0.
REQ-026 Synchronizer flops SHALL reset to the idle line levels: sclk 0, mosi 0, cs_n 1.
REQ-027 A reset released mid-frame SHALL cause the remainder of that frame to be ignored; reception resumes only after a fresh cs_n fall.

Structure
REQ-028 A shared package spi_pkg SHALL hold the state enum (IDLE, SHIFT, LOAD, ABORT), SPI_WIDTH_DEFAULT=16 and SPI_SYNC_DEFAULT=2.
REQ-029 A sub-module spi_sync (synchronizer plus rise/fall edge detector, one bit wide) SHALL be instantiated three times.

Verification
REQ-030 A 16-bit frame 0x0005 at SCLK=clk/10 -> o_valid pulses once, o_data=5, o_frame_err=0.
REQ-031 Back-to-back frames 0x00FF then 0x0100 -> o_valid pulses twice; o_miso during the second frame shifts out 0x00FF.
REQ-032 cs_n raised after 9 bits of 0xABCD -> o_frame_err pulses once and o_data keeps its prior value 0x0100.
REQ-033 A 17-bit frame -> o_frame_err pulses and o_data is unchanged; the following valid frame 0x1234 -> o_data=0x1234.
REQ-034 reset asserted after 8 bits, then released while cs_n stays low for the remaining 8 bits -> no o_valid pulse, o_data=0; the next full frame 0x0003 -> o_data=3.
REQ-035 Master-counter loopback (counts 0..5 from tick-driven frames) -> o_data matches each transmitted count within SYNC_STAGES+2 cycles of cs_n rise.
